// File: rtl/gpio_debounce_pkg.sv
// Shared types and limits for the debounced GPIO interrupt input block.
package gpio_debounce_pkg;

    localparam int unsigned MaxNumIn = 32;

    typedef enum logic {
        Stable,
        Counting
    } chan_state_e;

endpackage

// File: rtl/debounce_chan.sv
// One input channel: synchroniser, polarity invert, debounce FSM/counter and edge pulses.
module debounce_chan
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned CntWidth   = 20,
    parameter int unsigned SyncStages = 2,
    parameter logic        ResetState = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pin_i,
    input  logic                invert_i,
    input  logic [CntWidth-1:0] debounce_cycles_i,
    output logic                state_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                rise_next_o,
    output logic                fall_next_o
);

    logic [SyncStages-1:0] sync_q;
    logic                  level;
    chan_state_e           fsm_q, fsm_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [CntWidth-1:0]   cnt_sat;
    logic [CntWidth:0]     cnt_inc;
    logic [CntWidth-1:0]   dmin;
    logic                  state_q, state_d;
    logic                  rise_q, fall_q;
    logic                  update;

    assign level   = sync_q[SyncStages-1] ^ invert_i;
    assign dmin    = (debounce_cycles_i == '0) ? CntWidth'(1) : debounce_cycles_i;
    // One bit wider so the completion compare can never wrap.
    assign cnt_inc = {1'b0, cnt_q} + (CntWidth + 1)'(1);
    assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + CntWidth'(1);

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        update = 1'b0;
        case (fsm_q)
            Stable: begin
                cnt_d = '0;
                if (level != state_q) begin
                    if (dmin == CntWidth'(1)) begin
                        update = 1'b1;
                    end else begin
                        cnt_d = CntWidth'(1);
                        fsm_d = Counting;
                    end
                end
            end
            Counting: begin
                if (level == state_q) begin
                    cnt_d = '0;
                    fsm_d = Stable;
                end else if (cnt_inc >= {1'b0, dmin}) begin
                    update = 1'b1;
                    cnt_d  = '0;
                    fsm_d  = Stable;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            default: begin
                cnt_d = '0;
                fsm_d = Stable;
            end
        endcase
        state_d = update ? level : state_q;
    end

    assign rise_next_o = update & level;
    assign fall_next_o = update & ~level;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= {SyncStages{ResetState ^ invert_i}};
            fsm_q   <= Stable;
            cnt_q   <= '0;
            state_q <= ResetState;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SyncStages-2:0], pin_i};
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_next_o;
            fall_q  <= fall_next_o;
        end
    end

    assign state_o = state_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_debounce_irq.sv
// Debounced GPIO inputs with per-channel sticky edge interrupts and a registered summary irq.
module gpio_debounce_irq
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned      NumIn      = 16,
    parameter int unsigned      CntWidth   = 20,
    parameter int unsigned      SyncStages = 2,
    parameter logic [NumIn-1:0] ResetState = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumIn-1:0]    pins_i,
    input  logic [NumIn-1:0]    invert_i,
    input  logic [CntWidth-1:0] debounce_cycles_i,
    input  logic [NumIn-1:0]    rise_en_i,
    input  logic [NumIn-1:0]    fall_en_i,
    input  logic [NumIn-1:0]    irq_clear_i,
    output logic [NumIn-1:0]    state_o,
    output logic [NumIn-1:0]    rise_o,
    output logic [NumIn-1:0]    fall_o,
    output logic [NumIn-1:0]    irq_status_o,
    output logic                irq_o
);

    logic [NumIn-1:0] rise_next, fall_next;
    logic [NumIn-1:0] irq_set;
    logic [NumIn-1:0] irq_status_q, irq_status_d;
    logic             irq_q;

    for (genvar i = 0; i < NumIn; i++) begin : gen_chan
        debounce_chan #(
            .CntWidth  (CntWidth),
            .SyncStages(SyncStages),
            .ResetState(ResetState[i])
        ) u_chan (
            .clk_i            (clk_i),
            .rst_i            (rst_i),
            .pin_i            (pins_i[i]),
            .invert_i         (invert_i[i]),
            .debounce_cycles_i(debounce_cycles_i),
            .state_o          (state_o[i]),
            .rise_o           (rise_o[i]),
            .fall_o           (fall_o[i]),
            .rise_next_o      (rise_next[i]),
            .fall_next_o      (fall_next[i])
        );
    end

    // Status is set on the same edge the debounced level updates; a new event beats a clear.
    assign irq_set      = (rise_next & rise_en_i) | (fall_next & fall_en_i);
    assign irq_status_d = (irq_status_q & ~irq_clear_i) | irq_set;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_status_q <= irq_status_d;
            irq_q        <= |irq_status_q;
        end
    end

    assign irq_status_o = irq_status_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_gpio_debounce_irq.sv
// Randomised and directed bench for gpio_debounce_irq against a run-length behavioural model.
module tb_gpio_debounce_irq;

    localparam int unsigned N    = 16;
    localparam int unsigned CW   = 20;
    localparam int unsigned SYNC = 2;
    localparam logic [N-1:0] RST_STATE = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  pins, inv, ren, fen, clr;
    logic [CW-1:0] dcyc;
    logic [N-1:0]  dut_state, dut_rise, dut_fall, dut_stat;
    logic          dut_irq;

    int checks   = 0;
    int failures = 0;

    // Model: per channel, how many consecutive edges the conditioned input has disagreed
    // with the debounced level; the level flips once that run reaches max(D,1).
    logic [N-1:0] m_pipe [SYNC];
    logic [N-1:0] m_state, m_rise, m_fall, m_stat;
    logic         m_irq;
    int unsigned  m_run [N];

    always #5 clk = ~clk;

    gpio_debounce_irq #(
        .NumIn     (N),
        .CntWidth  (CW),
        .SyncStages(SYNC),
        .ResetState(RST_STATE)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .pins_i           (pins),
        .invert_i         (inv),
        .debounce_cycles_i(dcyc),
        .rise_en_i        (ren),
        .fall_en_i        (fen),
        .irq_clear_i      (clr),
        .state_o          (dut_state),
        .rise_o           (dut_rise),
        .fall_o           (dut_fall),
        .irq_status_o     (dut_stat),
        .irq_o            (dut_irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] s;
        int unsigned  d;
        if (rst) begin
            for (int k = 0; k < SYNC; k++) m_pipe[k] = RST_STATE ^ inv;
            m_state = RST_STATE;
            m_rise  = '0;
            m_fall  = '0;
            m_stat  = '0;
            m_irq   = 1'b0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            m_irq = |m_stat;
            s = m_pipe[SYNC-1] ^ inv;
            for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = pins;
            d = (dcyc == 0) ? 1 : int'(dcyc);
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                if (s[i] != m_state[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= d) begin
                        m_state[i] = s[i];
                        m_rise[i]  = s[i];
                        m_fall[i]  = ~s[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_stat = (m_stat & ~clr) | (m_rise & ren) | (m_fall & fen);
        end
    endtask

    task automatic compare();
        chk("state_o", dut_state, m_state);
        chk("rise_o", dut_rise, m_rise);
        chk("fall_o", dut_fall, m_fall);
        chk("irq_status_o", dut_stat, m_stat);
        chk("irq_o", dut_irq, m_irq);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    initial begin
        pins = '0; inv = '0; ren = '0; fen = '0; clr = '0; dcyc = 4; rst = 1'b1;
        step();
        step();
        chk("reset_state", dut_state, 0);
        chk("reset_irq", dut_irq, 0);
        chk("reset_status", dut_stat, 0);

        // Channel 0: level rises SyncStages + D = 6 cycles after release.
        pins[0] = 1'b1;
        rst = 1'b0;
        step();
        chk("irq_after_release", dut_irq, 0);
        repeat (4) step();
        chk("ch0_before_6", dut_state[0], 0);
        step();
        chk("ch0_state_at_6", dut_state[0], 1);
        chk("ch0_rise_at_6", dut_rise[0], 1);
        chk("model_ch0_at_6", m_state[0], 1);
        step();
        chk("ch0_rise_once", dut_rise[0], 0);

        // Channel 3: 7-cycle bounce at D=10, then a clean hold.
        dcyc = 10;
        ren  = 16'h0008;
        pins[3] = 1'b1;
        repeat (7) step();
        pins[3] = 1'b0;
        repeat (15) step();
        chk("ch3_bounce_state", dut_state[3], 0);
        chk("ch3_bounce_status", dut_stat[3], 0);
        pins[3] = 1'b1;
        repeat (11) step();
        chk("ch3_before_12", dut_state[3], 0);
        step();
        chk("ch3_state_at_12", dut_state[3], 1);
        clr[3] = 1'b1;
        step();
        clr = '0;
        step();

        // Channel 5: rise-only interrupt, then write-1-to-clear.
        dcyc = 3;
        ren  = 16'h0020;
        pins[5] = 1'b1;
        repeat (4) step();
        chk("ch5_status_early", dut_stat[5], 0);
        step();
        chk("ch5_state_rise", dut_state[5], 1);
        chk("ch5_status_set", dut_stat[5], 1);
        chk("ch5_irq_lag", dut_irq, 0);
        step();
        chk("ch5_irq_set", dut_irq, 1);
        pins[5] = 1'b0;
        repeat (6) step();
        chk("ch5_state_fall", dut_state[5], 0);
        chk("ch5_status_held", dut_stat[5], 1);
        clr[5] = 1'b1;
        step();
        clr = '0;
        chk("ch5_status_cleared", dut_stat[5], 0);
        chk("ch5_irq_still", dut_irq, 1);
        step();
        chk("ch5_irq_cleared", dut_irq, 0);

        // Channel 2: clear coincident with a new enabled edge; the set wins.
        ren = 16'h0004;
        fen = 16'h0004;
        pins[2] = 1'b1;
        repeat (5) step();
        chk("ch2_status_rise", dut_stat[2], 1);
        pins[2] = 1'b0;
        repeat (4) step();
        clr[2] = 1'b1;
        step();
        clr = '0;
        chk("ch2_fall_pulse", dut_fall[2], 1);
        chk("ch2_set_wins", dut_stat[2], 1);

        // Channel 1: D=0 behaves as D=1, then lowering D mid-count completes next edge.
        dcyc = 0;
        pins[1] = 1'b1;
        repeat (2) step();
        chk("ch1_d0_before", dut_state[1], 0);
        step();
        chk("ch1_d0_latency", dut_state[1], 1);
        for (int t = 0; t < 6; t++) begin
            pins[1] = ~pins[1];
            repeat (4) step();
        end
        pins[1] = 1'b0;
        dcyc = 1000;
        repeat (502) step();
        chk("ch1_d1000_holding", dut_state[1], 1);
        dcyc = 100;
        step();
        chk("ch1_d_lowered", dut_state[1], 0);
        chk("ch1_d_lowered_fall", dut_fall[1], 1);

        // Channel 7: invert toggle with the pin steady is debounced without sync delay.
        dcyc = 5;
        inv[7] = 1'b1;
        repeat (4) step();
        chk("ch7_inv_before", dut_state[7], 0);
        step();
        chk("ch7_inv_state", dut_state[7], 1);
        chk("ch7_inv_rise", dut_rise[7], 1);

        // Reset mid-count on channel 0 abandons the pending fall.
        pins[0] = 1'b0;
        dcyc = 10;
        repeat (6) step();
        rst = 1'b1;
        step();
        chk("ch0_rst_state", dut_state[0], 0);
        chk("ch0_rst_no_fall", dut_fall[0], 0);
        rst = 1'b0;
        repeat (3) step();

        // Random traffic: slow-ish pin changes, occasional invert/D/enable changes and clears.
        ren = N'($urandom);
        fen = N'($urandom);
        for (int c = 0; c < 4000; c++) begin
            pins = pins ^ N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 49) == 0) inv[$urandom_range(0, N - 1)] ^= 1'b1;
            if (c % 100 == 0) dcyc = CW'($urandom_range(0, 6));
            if (c % 250 == 0) begin
                ren = N'($urandom);
                fen = N'($urandom);
            end
            clr = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
            rst = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;
        clr = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
